// File: rtl/parking_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parking_pkg
// Description : Shared types and constants for the parking request generator.
// Revision    : 1.0 - initial release
// ============================================================================
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic REQ_ENTER = 1'b0;
    localparam logic REQ_EXIT  = 1'b1;

    localparam int SLOT_W = 2;
    localparam int DROP_W = 4;

    // Saturating add of up to two lost presses in one cycle.
    function automatic logic [DROP_W-1:0] sat_add(
        input logic [DROP_W-1:0] base,
        input logic [1:0]        inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, base} + {{(DROP_W-1){1'b0}}, inc};
        if (sum[DROP_W]) begin
            return '1;
        end
        return sum[DROP_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/parking_request_gen_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchroniser, debounce counter and registered
//               rising-edge pulse for one raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_level_prev;
    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_cnt        <= '0;
            rise         <= 1'b0;
        end else begin
            r_sync1      <= btn;
            r_sync2      <= r_sync1;
            r_level_prev <= r_level;
            rise         <= r_level & ~r_level_prev;

            // Level must disagree for DEBOUNCE_CYCLES consecutive samples.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/parking_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : parking_request_gen
// Description : Debounces enter/exit buttons and issues spaced, mutually
//               exclusive single-cycle requests to the parking controller.
// Revision    : 1.0 - initial release
// ============================================================================
module parking_request_gen
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter_btn,
    input  logic              exit_btn,
    input  logic [SLOT_W-1:0] exit_sel,
    input  logic              door_busy,
    output logic              enter,
    output logic              exit,
    output logic [SLOT_W-1:0] exitLocation,
    output logic              pending_enter,
    output logic              pending_exit,
    output logic [DROP_W-1:0] drop_count
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES);

    logic              w_enter_rise;
    logic              w_exit_rise;
    logic [SLOT_W-1:0] r_sel_s1;
    logic [SLOT_W-1:0] r_sel_s2;
    logic [SLOT_W-1:0] r_loc;
    state_t            r_state;
    logic [7:0]        r_hold_cnt;
    logic              r_last_served;

    logic w_can_issue;
    logic w_pick_exit;
    logic w_issue_enter;
    logic w_issue_exit;
    logic w_drop_enter;
    logic w_drop_exit;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_db (
        .clk   (clk),
        .reset (reset),
        .btn   (enter_btn),
        .rise  (w_enter_rise)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_exit_db (
        .clk   (clk),
        .reset (reset),
        .btn   (exit_btn),
        .rise  (w_exit_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_s1 <= '0;
            r_sel_s2 <= '0;
        end else begin
            r_sel_s1 <= exit_sel;
            r_sel_s2 <= r_sel_s1;
        end
    end

    // With both pending, serve whichever type was not served last.
    always_comb begin
        w_can_issue   = (r_state == IDLE) && !door_busy && (pending_enter || pending_exit);
        w_pick_exit   = pending_exit && (!pending_enter || (r_last_served == REQ_ENTER));
        w_issue_enter = w_can_issue && !w_pick_exit;
        w_issue_exit  = w_can_issue && w_pick_exit;
        // A fresh edge landing on the issue of its own type re-arms rather than drops.
        w_drop_enter  = w_enter_rise && pending_enter && !w_issue_enter;
        w_drop_exit   = w_exit_rise && pending_exit && !w_issue_exit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            r_last_served <= REQ_EXIT;
            r_loc         <= '0;
            enter         <= 1'b0;
            exit          <= 1'b0;
            exitLocation  <= '0;
            pending_enter <= 1'b0;
            pending_exit  <= 1'b0;
            drop_count    <= '0;
        end else begin
            enter      <= 1'b0;
            exit       <= 1'b0;
            drop_count <= sat_add(drop_count, {1'b0, w_drop_enter} + {1'b0, w_drop_exit});

            if (w_enter_rise) begin
                pending_enter <= 1'b1;
            end else if (w_issue_enter) begin
                pending_enter <= 1'b0;
            end

            if (w_exit_rise) begin
                pending_exit <= 1'b1;
            end else if (w_issue_exit) begin
                pending_exit <= 1'b0;
            end

            if (w_exit_rise && !w_drop_exit) begin
                r_loc <= r_sel_s2;
            end

            case (r_state)
                IDLE: begin
                    if (w_can_issue) begin
                        enter         <= w_issue_enter;
                        exit          <= w_issue_exit;
                        r_last_served <= w_pick_exit ? REQ_EXIT : REQ_ENTER;
                        r_hold_cnt    <= HOLD_LOAD;
                        r_state       <= ISSUE;
                        if (w_issue_exit) begin
                            exitLocation <= r_loc;
                        end
                    end
                end
                ISSUE: begin
                    if (HOLD_LOAD == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                        r_state    <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (r_hold_cnt == 8'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parking_request_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_request_gen
// Description : Directed and random stimulus for parking_request_gen, checked
//               every cycle against a cycle-indexed behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_request_gen;

    localparam int DEB  = 4;
    localparam int HOLD = 2;
    localparam int NMAX = 8192;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       enter_btn = 1'b0;
    logic       exit_btn  = 1'b0;
    logic       door_busy = 1'b0;
    logic [1:0] exit_sel  = 2'd0;
    logic       enter;
    logic       exit;
    logic [1:0] exitLocation;
    logic       pending_enter;
    logic       pending_exit;
    logic [3:0] drop_count;

    parking_request_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter_btn    (enter_btn),
        .exit_btn     (exit_btn),
        .exit_sel     (exit_sel),
        .door_busy    (door_busy),
        .enter        (enter),
        .exit         (exit),
        .exitLocation (exitLocation),
        .pending_enter(pending_enter),
        .pending_exit (pending_exit),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Raw inputs seen at each rising edge, indexed by edge number.
    bit         h_e[NMAX];
    bit         h_x[NMAX];
    logic [1:0] h_s[NMAX];

    // Behavioural model: run lengths, capture times and an issue-ready time.
    bit         m_db_e, m_db_x;
    int         m_run_e, m_run_x;
    int         cap_e_q[$];
    int         cap_x_q[$];
    bit         m_pe, m_px, m_last, m_en, m_ex;
    logic [1:0] m_loc, m_xloc;
    int         m_drop, m_ready, last_rst;

    int n_enter = 0, n_exit = 0;
    int last_e_cyc = -1000, last_x_cyc = -1000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic deb(input bit s, inout bit db, inout int run, output bit rose);
        rose = 1'b0;
        if (s != db) begin
            run++;
            if (run >= DEB) begin
                db   = s;
                run  = 0;
                rose = s;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge(input int t);
        bit         se, sx, re, rx, ix;
        logic [1:0] ss;
        if (reset) begin
            m_db_e = 0; m_db_x = 0; m_run_e = 0; m_run_x = 0;
            cap_e_q.delete(); cap_x_q.delete();
            m_pe = 0; m_px = 0; m_loc = 2'd0; m_drop = 0; m_last = 1'b1;
            m_en = 0; m_ex = 0; m_xloc = 2'd0;
            m_ready = t + 1; last_rst = t;
            return;
        end
        // Buttons reach the debouncer two edges after being sampled.
        se = (t - 2 > last_rst) ? h_e[t-2] : 1'b0;
        sx = (t - 2 > last_rst) ? h_x[t-2] : 1'b0;
        ss = (t - 2 > last_rst) ? h_s[t-2] : 2'd0;
        deb(se, m_db_e, m_run_e, re);
        if (re) cap_e_q.push_back(t + 2);
        deb(sx, m_db_x, m_run_x, rx);
        if (rx) cap_x_q.push_back(t + 2);

        m_en = 0; m_ex = 0; ix = 0;
        if (t >= m_ready && !door_busy && (m_pe || m_px)) begin
            ix      = m_px && (!m_pe || m_last == 1'b0);
            m_last  = ix;
            m_ready = t + HOLD + 2;
            if (ix) begin
                m_ex = 1; m_px = 0; m_xloc = m_loc;
            end else begin
                m_en = 1; m_pe = 0;
            end
        end
        if (cap_e_q.size() > 0 && cap_e_q[0] == t) begin
            void'(cap_e_q.pop_front());
            if (m_pe) m_drop = (m_drop < 15) ? m_drop + 1 : 15;
            else      m_pe = 1;
        end
        if (cap_x_q.size() > 0 && cap_x_q[0] == t) begin
            void'(cap_x_q.pop_front());
            if (m_px) m_drop = (m_drop < 15) ? m_drop + 1 : 15;
            else begin
                m_px  = 1;
                m_loc = ss;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        h_e[cyc] = enter_btn;
        h_x[cyc] = exit_btn;
        h_s[cyc] = exit_sel;
        model_edge(cyc);
        #1;
        chk("enter", 32'(enter), 32'(m_en));
        chk("exit", 32'(exit), 32'(m_ex));
        chk("exitLocation", 32'(exitLocation), 32'(m_xloc));
        chk("pending_enter", 32'(pending_enter), 32'(m_pe));
        chk("pending_exit", 32'(pending_exit), 32'(m_px));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("enter_and_exit", 32'(enter & exit), 32'd0);
        if (enter === 1'b1) begin n_enter++; last_e_cyc = cyc; end
        if (exit === 1'b1)  begin n_exit++;  last_x_cyc = cyc; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int e0, ne, nx, nb, he, hx, hb;

        // Reset state
        run(3);
        chk("rst_enter", 32'(enter), 32'd0);
        chk("rst_exit", 32'(exit), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_loc", 32'(exitLocation), 32'd0);
        reset = 1'b0;

        // Held enter: exact latency
        enter_btn = 1'b1;
        e0 = cyc + 1;
        ne = n_enter;
        for (int i = 0; i < 20 && n_enter == ne; i++) step();
        chk("t1_latency", 32'(last_e_cyc - e0), 32'(DEB + 4));
        chk("t1_exit_quiet", 32'(n_exit), 32'd0);
        enter_btn = 1'b0;
        run(15);

        // Short glitch is rejected
        ne = n_enter;
        enter_btn = 1'b1;
        run(DEB - 1);
        enter_btn = 1'b0;
        run(20);
        chk("t2_no_enter", 32'(n_enter - ne), 32'd0);
        chk("t2_drop", 32'(drop_count), 32'd0);

        // Exit slot is latched at capture time
        exit_sel = 2'b10;
        run(3);
        exit_btn = 1'b1;
        for (int i = 0; i < 20 && pending_exit !== 1'b1; i++) step();
        exit_sel = 2'b01;
        nx = n_exit;
        for (int i = 0; i < 10 && n_exit == nx; i++) step();
        chk("t3_pulse", 32'(n_exit - nx), 32'd1);
        chk("t3_loc", 32'(exitLocation), 32'd2);
        exit_btn = 1'b0;
        run(15);

        // Simultaneous presses: enter first after reset, then round-robin
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        enter_btn = 1'b1; exit_btn = 1'b1;
        ne = n_enter; nx = n_exit;
        for (int i = 0; i < 30 && (n_enter == ne || n_exit == nx); i++) step();
        chk("t4_gap_enter_first", 32'(last_x_cyc - last_e_cyc), 32'(HOLD + 2));
        enter_btn = 1'b0; exit_btn = 1'b0;
        run(15);
        enter_btn = 1'b1;
        ne = n_enter;
        for (int i = 0; i < 20 && n_enter == ne; i++) step();
        enter_btn = 1'b0;
        run(15);
        enter_btn = 1'b1; exit_btn = 1'b1;
        ne = n_enter; nx = n_exit;
        for (int i = 0; i < 30 && (n_enter == ne || n_exit == nx); i++) step();
        chk("t4_gap_exit_first", 32'(last_e_cyc - last_x_cyc), 32'(HOLD + 2));
        enter_btn = 1'b0; exit_btn = 1'b0;
        run(15);

        // door_busy stalls issue; repeated presses are dropped
        door_busy = 1'b1;
        ne = n_enter;
        enter_btn = 1'b1; run(12);
        enter_btn = 1'b0; run(10);
        enter_btn = 1'b1; run(12);
        chk("t5_pending", 32'(pending_enter), 32'd1);
        chk("t5_drop", 32'(drop_count), 32'd1);
        chk("t5_no_pulse", 32'(n_enter - ne), 32'd0);
        enter_btn = 1'b0; run(8);
        door_busy = 1'b0;
        step();
        chk("t5_issue_next", 32'(n_enter - ne), 32'd1);
        run(6);
        door_busy = 1'b1;
        for (int i = 0; i < 21; i++) begin
            enter_btn = 1'b1; run(8);
            enter_btn = 1'b0; run(8);
        end
        chk("t5_saturate", 32'(drop_count), 32'd15);
        door_busy = 1'b0;
        run(10);

        // Reset during holdoff discards the pending request
        enter_btn = 1'b1; exit_btn = 1'b1;
        nb = n_enter + n_exit;
        for (int i = 0; i < 30 && n_enter + n_exit == nb; i++) step();
        step();
        chk("t6_pending_before_rst", 32'(pending_enter | pending_exit), 32'd1);
        reset = 1'b1; enter_btn = 1'b0; exit_btn = 1'b0;
        step();
        chk("t6_rst_enter", 32'(enter), 32'd0);
        chk("t6_rst_exit", 32'(exit), 32'd0);
        chk("t6_rst_pending", 32'(pending_enter | pending_exit), 32'd0);
        reset = 1'b0;
        nb = n_enter + n_exit;
        run(30);
        chk("t6_quiet", 32'(n_enter + n_exit - nb), 32'd0);

        // Random buttons, slot switches, door activity and occasional reset
        he = 0; hx = 0; hb = 0;
        for (int i = 0; i < 2000; i++) begin
            if (he == 0) begin enter_btn = 1'($urandom_range(0, 1)); he = $urandom_range(1, 12); end
            else he--;
            if (hx == 0) begin exit_btn = 1'($urandom_range(0, 1)); hx = $urandom_range(1, 12); end
            else hx--;
            if (hb == 0) begin door_busy = ($urandom_range(0, 9) < 3); hb = $urandom_range(1, 20); end
            else hb--;
            if ($urandom_range(0, 7) == 0) exit_sel = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0; door_busy = 1'b0; enter_btn = 1'b0; exit_btn = 1'b0;
        run(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
